tlb_param: RTL and testbench
============================

TLB_PARAM -- requirements
Module: tlb_param

Interface
REQ-001 The parameter TLBNUM SHALL default to 16 and set the entry count; legal values are powers of two from 4 to 64.
REQ-002 The parameter SEARCH_REG SHALL default to 0 and select the search mode: 0 = combinational search, 1 = registered search.
REQ-003 The localparam IDXW SHALL equal $clog2(TLBNUM) and set the index width.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Ports s0_vppn / s1_vppn SHALL be inputs, 19 bits: search VA[31:13].
REQ-007 Ports s0_va_bit12 / s1_va_bit12 SHALL be inputs, 1 bit: search VA[12].
REQ-008 Ports s0_asid / s1_asid SHALL be inputs, 10 bits: search ASID.
REQ-009 Ports s0_found / s1_found SHALL be outputs, 1 bit: hit flag.
REQ-010 Ports s0_index / s1_index SHALL be outputs, IDXW bits: hit entry index.
REQ-011 Ports s0_ppn / s1_ppn (20), s0_ps / s1_ps (6), s0_plv / s1_plv (2), s0_mat / s1_mat (2), s0_d / s1_d (1) and s0_v / s1_v (1) SHALL be outputs carrying the selected half-page fields.
REQ-012 Port we SHALL be an input, 1 bit: indexed write strobe (TLBWR).
REQ-013 Port w_index SHALL be an input, IDXW bits: write index.
REQ-014 Port fill SHALL be an input, 1 bit: fill strobe (TLBFILL) that writes to fill_index.
REQ-015 Port w_entry SHALL be an input, 89 bits: packed entry to write.
REQ-016 Port fill_index SHALL be an output, IDXW bits: the victim index the next fill will use.
REQ-017 Port r_index SHALL be an input, IDXW bits: read index (TLBRD).
REQ-018 Port r_entry SHALL be an output, 89 bits: packed entry at r_index.
REQ-019 Port invtlb_valid SHALL be an input, 1 bit: invalidate strobe.
REQ-020 Port invtlb_op SHALL be an input, 5 bits: INVTLB opcode.
REQ-021 Port invtlb_asid SHALL be an input, 10 bits: INVTLB ASID operand.
REQ-022 Port invtlb_vppn SHALL be an input, 19 bits: INVTLB VA[31:13] operand.

Function
REQ-023 The entry packing SHALL be, MSB first: e[88], vppn[87:69], ps[68:63], asid[62:53], g[52], ppn0[51:32], plv0[31:30], mat0[29:28], d0[27], v0[26], ppn1[25:6], plv1[5:4], mat1[3:2], d1[1], v1[0].
REQ-024 An entry SHALL match a search when e=1, (g=1 or asid equals the search ASID), and the VPPN compares equal: bits [18:0] when ps≠21, bits [18:9] when ps=21.
REQ-025 Half-page select SHALL be va_bit12 when ps≠21 and search vppn[8] when ps=21; 0 selects the ppn0 group, 1 selects the ppn1 group.
REQ-026 On multiple hits, the lowest matching index SHALL win.
REQ-027 On a miss, found, index and all field outputs SHALL be 0.
REQ-028 With SEARCH_REG=0, search outputs SHALL be combinational from inputs and current table contents.
REQ-029 With SEARCH_REG=1, results SHALL be captured at each rising edge from the inputs and pre-edge table, appearing one cycle after the inputs.
REQ-030 The two search ports SHALL be fully independent and usable in the same cycle.
REQ-031 When we=1, w_entry SHALL be stored at w_index on the edge.
REQ-032 When fill=1 and we=0, w_entry SHALL be stored at the current fill_index.
REQ-033 When we and fill are both 1, we SHALL win and the fill is dropped.
REQ-034 fill_index SHALL increment by 1 every cycle, wrapping from TLBNUM-1 to 0, independent of fill.
REQ-035 r_entry SHALL be combinational from the stored entry at r_index, with no bypass of a same-edge write.
REQ-036 INVTLB SHALL act on the edge with invtlb_valid=1, clearing e per op (operand compare uses REQ-024 VPPN rule): 0/1 all entries; 2 g=1; 3 g=0; 4 g=0 and asid=invtlb_asid; 5 as op 4 plus VPPN match; 6 (g=1 or asid match) and VPPN match; 7–31 no effect.
REQ-037 INVTLB SHALL evaluate on pre-edge contents; if a write targets the same index in that cycle, the written entry SHALL be stored unmodified.

Reset
REQ-038 While reset=1 at an edge, all entry e bits SHALL be cleared, fill_index SHALL be set to 0, and registered search outputs SHALL be set to 0; reset dominates we, fill and invtlb; other entry fields are don't-care.

Verification
REQ-039 Reset, then search any VA -> found=0 and all outputs 0; fill_index=0, then 1 the next cycle.
REQ-040 Write index 3 with {e=1, vppn=0x12345, ps=12, asid=5, g=0, ppn1=0xABCDE, v1=1}; search vppn=0x12345, bit12=1, asid=5 -> found=1, index=3, ppn=0xABCDE, v=1; asid=6 -> miss.
REQ-041 Write index 1 with a ps=21 entry, vppn=0x7FE00; search vppn=0x7FFFF -> hit on the odd half; search vppn=0x7FC00 -> miss; the same entry duplicated at index 0 -> index=0 reported.
REQ-042 Assert we (w_index=2) and fill together -> only entry 2 written; fill_index slot unchanged; INVTLB op 4 asid=5 in the same cycle as a write to index 3 -> index 3 holds new data, other asid-5 non-global entries invalid.
REQ-043 With SEARCH_REG=1, a hit appears exactly one cycle after the inputs; reset asserted mid-sequence -> next cycle found=0 on both ports and fill_index=0.

Source files
------------

// File: rtl/tlb_param.sv
// Fully associative TLB with two independent search ports, indexed write, round-robin fill,
// read-back and INVTLB invalidation. Search results are optionally registered.
module tlb_param #(
  parameter int unsigned TLBNUM     = 16,
  parameter int unsigned SEARCH_REG = 0,
  localparam int unsigned IDXW      = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  // search port 0
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  // search port 1
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  // write / fill
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            fill,
  input  logic [88:0]     w_entry,
  output logic [IDXW-1:0] fill_index,
  // read
  input  logic [IDXW-1:0] r_index,
  output logic [88:0]     r_entry,
  // invalidate
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic [9:0]      invtlb_asid,
  input  logic [18:0]     invtlb_vppn
);

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } res_t;

  logic [88:0]     tlb_q [TLBNUM];
  logic [88:0]     tlb_d [TLBNUM];
  logic [IDXW-1:0] fill_q, fill_d;
  res_t            res0_c, res1_c, res0, res1;

  // 4 MB pages (ps=21) ignore the low 9 VPPN bits.
  function automatic logic vppn_hit(logic [88:0] ent, logic [18:0] vppn);
    if (ent[68:63] == 6'd21) begin
      return ent[87:78] == vppn[18:9];
    end
    return ent[87:69] == vppn;
  endfunction

  function automatic logic search_hit(logic [88:0] ent, logic [18:0] vppn, logic [9:0] asid);
    return ent[88] && (ent[52] || (ent[62:53] == asid)) && vppn_hit(ent, vppn);
  endfunction

  function automatic res_t pick(logic [88:0] ent, logic [IDXW-1:0] idx, logic bit12,
                                logic [18:0] vppn);
    res_t r;
    logic odd;
    odd     = (ent[68:63] == 6'd21) ? vppn[8] : bit12;
    r.found = 1'b1;
    r.index = idx;
    r.ps    = ent[68:63];
    if (odd) begin
      r.ppn = ent[25:6];
      r.plv = ent[5:4];
      r.mat = ent[3:2];
      r.d   = ent[1];
      r.v   = ent[0];
    end else begin
      r.ppn = ent[51:32];
      r.plv = ent[31:30];
      r.mat = ent[29:28];
      r.d   = ent[27];
      r.v   = ent[26];
    end
    return r;
  endfunction

  function automatic logic inv_hit(logic [88:0] ent, logic [4:0] op, logic [9:0] asid,
                                   logic [18:0] vppn);
    logic g, asid_eq, va_eq;
    g       = ent[52];
    asid_eq = (ent[62:53] == asid);
    va_eq   = vppn_hit(ent, vppn);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && asid_eq;
      5'd5:       return !g && asid_eq && va_eq;
      5'd6:       return (g || asid_eq) && va_eq;
      default:    return 1'b0;
    endcase
  endfunction

  // Scan high to low so the lowest matching index is the last assignment and wins.
  always_comb begin
    res0_c = '0;
    res1_c = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (search_hit(tlb_q[i], s0_vppn, s0_asid)) begin
        res0_c = pick(tlb_q[i], IDXW'(i), s0_va_bit12, s0_vppn);
      end
      if (search_hit(tlb_q[i], s1_vppn, s1_asid)) begin
        res1_c = pick(tlb_q[i], IDXW'(i), s1_va_bit12, s1_vppn);
      end
    end
  end

  if (SEARCH_REG != 0) begin : g_reg
    res_t res0_q, res1_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        res0_q <= '0;
        res1_q <= '0;
      end else begin
        res0_q <= res0_c;
        res1_q <= res1_c;
      end
    end
    assign res0 = res0_q;
    assign res1 = res1_q;
  end else begin : g_comb
    assign res0 = res0_c;
    assign res1 = res1_c;
  end

  // Invalidation looks at pre-edge contents; a same-cycle write then overrides its slot.
  always_comb begin
    tlb_d = tlb_q;
    for (int i = 0; i < int'(TLBNUM); i++) begin
      if (invtlb_valid && inv_hit(tlb_q[i], invtlb_op, invtlb_asid, invtlb_vppn)) begin
        tlb_d[i][88] = 1'b0;
      end
    end
    if (we) begin
      tlb_d[w_index] = w_entry;
    end else if (fill) begin
      tlb_d[fill_q] = w_entry;
    end
  end

  assign fill_d = (fill_q == IDXW'(TLBNUM - 1)) ? '0 : fill_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      for (int i = 0; i < int'(TLBNUM); i++) begin
        tlb_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      tlb_q  <= tlb_d;
    end
  end

  assign fill_index = fill_q;
  assign r_entry    = tlb_q[r_index];

  assign s0_found = res0.found;
  assign s0_index = res0.index;
  assign s0_ppn   = res0.ppn;
  assign s0_ps    = res0.ps;
  assign s0_plv   = res0.plv;
  assign s0_mat   = res0.mat;
  assign s0_d     = res0.d;
  assign s0_v     = res0.v;

  assign s1_found = res1.found;
  assign s1_index = res1.index;
  assign s1_ppn   = res1.ppn;
  assign s1_ps    = res1.ps;
  assign s1_plv   = res1.plv;
  assign s1_mat   = res1.mat;
  assign s1_d     = res1.d;
  assign s1_v     = res1.v;

endmodule

// File: tb/tb_tlb_param.sv
// Scoreboard bench for tlb_param: a combinational-search and a registered-search instance share
// all stimulus; expectations carry the cycle in which the monitor must sample them.
module tb_tlb_param;

  localparam int KS0C = 0, KS1C = 1, KS0R = 2, KS1R = 3;
  localparam int KFC = 4, KFR = 5, KRE = 6, KRV = 7, KRR = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vppn, s1_vppn, invtlb_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid, invtlb_asid;
  logic        we, fill, invtlb_valid;
  logic [3:0]  w_index, r_index;
  logic [88:0] w_entry;
  logic [4:0]  invtlb_op;

  logic        c_s0_found, c_s1_found, r_s0_found, r_s1_found;
  logic [3:0]  c_s0_index, c_s1_index, r_s0_index, r_s1_index;
  logic [19:0] c_s0_ppn, c_s1_ppn, r_s0_ppn, r_s1_ppn;
  logic [5:0]  c_s0_ps, c_s1_ps, r_s0_ps, r_s1_ps;
  logic [1:0]  c_s0_plv, c_s1_plv, r_s0_plv, r_s1_plv;
  logic [1:0]  c_s0_mat, c_s1_mat, r_s0_mat, r_s1_mat;
  logic        c_s0_d, c_s1_d, r_s0_d, r_s1_d;
  logic        c_s0_v, c_s1_v, r_s0_v, r_s1_v;
  logic [3:0]  c_fill_index, r_fill_index;
  logic [88:0] c_r_entry, r_r_entry;

  typedef struct {
    int          kind;
    int          due;
    logic [88:0] val;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tlb_param #(.TLBNUM(16), .SEARCH_REG(0)) u_comb (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(c_s0_found), .s0_index(c_s0_index), .s0_ppn(c_s0_ppn), .s0_ps(c_s0_ps),
    .s0_plv(c_s0_plv), .s0_mat(c_s0_mat), .s0_d(c_s0_d), .s0_v(c_s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(c_s1_found), .s1_index(c_s1_index), .s1_ppn(c_s1_ppn), .s1_ps(c_s1_ps),
    .s1_plv(c_s1_plv), .s1_mat(c_s1_mat), .s1_d(c_s1_d), .s1_v(c_s1_v),
    .we(we), .w_index(w_index), .fill(fill), .w_entry(w_entry), .fill_index(c_fill_index),
    .r_index(r_index), .r_entry(c_r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vppn(invtlb_vppn)
  );

  tlb_param #(.TLBNUM(16), .SEARCH_REG(1)) u_reg (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(r_s0_found), .s0_index(r_s0_index), .s0_ppn(r_s0_ppn), .s0_ps(r_s0_ps),
    .s0_plv(r_s0_plv), .s0_mat(r_s0_mat), .s0_d(r_s0_d), .s0_v(r_s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(r_s1_found), .s1_index(r_s1_index), .s1_ppn(r_s1_ppn), .s1_ps(r_s1_ps),
    .s1_plv(r_s1_plv), .s1_mat(r_s1_mat), .s1_d(r_s1_d), .s1_v(r_s1_v),
    .we(we), .w_index(w_index), .fill(fill), .w_entry(w_entry), .fill_index(r_fill_index),
    .r_index(r_index), .r_entry(r_r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vppn(invtlb_vppn)
  );

  function automatic logic [36:0] rs(logic f, logic [3:0] idx, logic [19:0] ppn, logic [5:0] ps,
                                     logic [1:0] plv, logic [1:0] mat, logic d, logic v);
    return {f, idx, ppn, ps, plv, mat, d, v};
  endfunction

  function automatic logic [88:0] mk(logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid,
                                     logic g, logic [19:0] ppn0, logic [1:0] plv0,
                                     logic [1:0] mat0, logic d0, logic v0, logic [19:0] ppn1,
                                     logic [1:0] plv1, logic [1:0] mat1, logic d1, logic v1);
    return {1'b1, vppn, ps, asid, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1};
  endfunction

  function automatic logic [88:0] got(int kind);
    case (kind)
      KS0C: return 89'({c_s0_found, c_s0_index, c_s0_ppn, c_s0_ps, c_s0_plv, c_s0_mat,
                        c_s0_d, c_s0_v});
      KS1C: return 89'({c_s1_found, c_s1_index, c_s1_ppn, c_s1_ps, c_s1_plv, c_s1_mat,
                        c_s1_d, c_s1_v});
      KS0R: return 89'({r_s0_found, r_s0_index, r_s0_ppn, r_s0_ps, r_s0_plv, r_s0_mat,
                        r_s0_d, r_s0_v});
      KS1R: return 89'({r_s1_found, r_s1_index, r_s1_ppn, r_s1_ps, r_s1_plv, r_s1_mat,
                        r_s1_d, r_s1_v});
      KFC:  return 89'(c_fill_index);
      KFR:  return 89'(r_fill_index);
      KRE:  return c_r_entry;
      KRV:  return 89'(c_r_entry[88]);
      default: return r_r_entry;
    endcase
  endfunction

  task automatic push(int kind, int due, logic [88:0] val, string name);
    item_t it;
    it.kind = kind;
    it.due  = due;
    it.val  = val;
    it.name = name;
    sb.push_back(it);
  endtask

  // Combinational result is due this cycle, registered result one cycle later.
  task automatic search(int port, logic [18:0] vppn, logic b12, logic [9:0] asid,
                        logic [36:0] exp, bit reg_zero, string name);
    if (port == 0) begin
      s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
      push(KS0C, cyc, 89'(exp), name);
      push(KS0R, cyc + 1, reg_zero ? 89'd0 : 89'(exp), {name, "_reg"});
    end else begin
      s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid;
      push(KS1C, cyc, 89'(exp), name);
      push(KS1R, cyc + 1, reg_zero ? 89'd0 : 89'(exp), {name, "_reg"});
    end
  endtask

  task automatic chk_fill(int v, string name);
    push(KFC, cyc, 89'(v), name);
    push(KFR, cyc, 89'(v), {name, "_reg"});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    we = 1'b0; fill = 1'b0; invtlb_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    item_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        logic [88:0] gv;
        gv = got(sb[i].kind);
        n_chk++;
        if (gv === sb[i].val) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", sb[i].name, cyc, gv,
                      sb[i].val);
      end else if (sb[i].due < cyc) begin
        n_chk++;
        $display("FAIL %s: not sampled (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  localparam logic [36:0] MISS = 37'd0;

  initial begin
    logic [88:0] e1, e2, e3, e3b, e4;
    e3  = mk(19'h12345, 6'd12, 10'd5, 1'b0, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0,
             20'hABCDE, 2'd0, 2'd0, 1'b0, 1'b1);
    e1  = mk(19'h7FE00, 6'd21, 10'd0, 1'b1, 20'h11111, 2'd1, 2'd2, 1'b0, 1'b1,
             20'h22222, 2'd3, 2'd1, 1'b1, 1'b1);
    e2  = mk(19'h00042, 6'd12, 10'd5, 1'b0, 20'h33333, 2'd0, 2'd0, 1'b0, 1'b1,
             20'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    e4  = mk(19'h00100, 6'd12, 10'd8, 1'b0, 20'h44444, 2'd0, 2'd0, 1'b0, 1'b1,
             20'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    e3b = mk(19'h12345, 6'd12, 10'd5, 1'b0, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0,
             20'h55555, 2'd0, 2'd0, 1'b0, 1'b1);

    reset = 1'b1; we = 1'b0; fill = 1'b0; w_index = '0; w_entry = '0; r_index = '0;
    invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0; invtlb_vppn = '0;
    s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
    s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // C0: empty after reset
    chk_fill(0, "fill_after_reset");
    search(0, 19'h12345, 1'b1, 10'd5, MISS, 0, "s0_reset_miss");
    search(1, 19'h7FFFF, 1'b0, 10'd0, MISS, 0, "s1_reset_miss");
    next();
    // C1: write entry 3; search sees pre-edge (empty) table
    chk_fill(1, "fill_incr");
    search(0, 19'h12345, 1'b1, 10'd5, MISS, 0, "s0_before_write");
    we = 1'b1; w_index = 4'd3; w_entry = e3;
    next();
    // C2
    search(0, 19'h12345, 1'b1, 10'd5, rs(1, 3, 20'hABCDE, 12, 0, 0, 0, 1), 0, "s0_hit3_odd");
    search(1, 19'h12345, 1'b1, 10'd6, MISS, 0, "s1_asid_miss");
    r_index = 4'd3;
    push(KRE, cyc, e3, "rd_entry3");
    next();
    // C3: even half of entry 3; write 4 MB entry at 1
    search(0, 19'h12345, 1'b0, 10'd5, rs(1, 3, 20'h0, 12, 0, 0, 0, 0), 0, "s0_hit3_even");
    we = 1'b1; w_index = 4'd1; w_entry = e1;
    next();
    // C4: 4 MB page odd half via vppn[8]; duplicate entry at 0
    search(0, 19'h7FFFF, 1'b0, 10'd9, rs(1, 1, 20'h22222, 21, 3, 1, 1, 1), 0, "s0_big_odd");
    search(1, 19'h7FC00, 1'b0, 10'd9, MISS, 0, "s1_big_miss");
    we = 1'b1; w_index = 4'd0; w_entry = e1;
    next();
    // C5: lowest index wins
    search(0, 19'h7FFFF, 1'b0, 10'd9, rs(1, 0, 20'h22222, 21, 3, 1, 1, 1), 0, "s0_lowest_idx");
    search(1, 19'h7FE00, 1'b1, 10'd9, rs(1, 0, 20'h11111, 21, 1, 2, 0, 1), 0, "s1_big_even");
    next();
    // C6: we and fill together -> only index 2 written, slot 6 untouched
    chk_fill(6, "fill_c6");
    we = 1'b1; fill = 1'b1; w_index = 4'd2; w_entry = e2;
    next();
    // C7
    search(0, 19'h00042, 1'b0, 10'd5, rs(1, 2, 20'h33333, 12, 0, 0, 0, 1), 0, "s0_we_wins");
    r_index = 4'd6;
    push(KRV, cyc, 89'd0, "fill_slot_untouched");
    next();
    // C8: plain fill lands at fill_index 8
    chk_fill(8, "fill_c8");
    r_index = 4'd2;
    push(KRE, cyc, e2, "rd_entry2");
    fill = 1'b1; w_entry = e4;
    next();
    // C9: INVTLB op 4 asid 5 with write to index 3 in the same cycle
    search(0, 19'h00100, 1'b0, 10'd8, rs(1, 8, 20'h44444, 12, 0, 0, 0, 1), 0, "s0_fill_hit");
    we = 1'b1; w_index = 4'd3; w_entry = e3b;
    invtlb_valid = 1'b1; invtlb_op = 5'd4; invtlb_asid = 10'd5; invtlb_vppn = 19'h0;
    next();
    // C10
    search(0, 19'h12345, 1'b1, 10'd5, rs(1, 3, 20'h55555, 12, 0, 0, 0, 1), 0, "s0_inv_wr_kept");
    search(1, 19'h00042, 1'b0, 10'd5, MISS, 0, "s1_inv_asid5");
    r_index = 4'd8;
    push(KRE, cyc, e4, "rd_entry8");
    push(KRR, cyc, e4, "rd_entry8_reg");
    invtlb_valid = 1'b1; invtlb_op = 5'd6; invtlb_asid = 10'd0; invtlb_vppn = 19'h7FFFF;
    next();
    // C11: op 6 removed the global 4 MB entries; op 9 must do nothing
    search(0, 19'h7FFFF, 1'b0, 10'd9, MISS, 0, "s0_inv_op6");
    search(1, 19'h00100, 1'b0, 10'd8, rs(1, 8, 20'h44444, 12, 0, 0, 0, 1), 0, "s1_op6_keep");
    r_index = 4'd2;
    push(KRV, cyc, 89'd0, "rd_entry2_invalid");
    invtlb_valid = 1'b1; invtlb_op = 5'd9; invtlb_asid = 10'd8; invtlb_vppn = 19'h00100;
    next();
    // C12: reset mid-sequence; registered outputs must read 0 next cycle
    chk_fill(12, "fill_c12");
    search(0, 19'h00100, 1'b0, 10'd8, rs(1, 8, 20'h44444, 12, 0, 0, 0, 1), 1, "s0_op9_keep");
    search(1, 19'h12345, 1'b1, 10'd5, rs(1, 3, 20'h55555, 12, 0, 0, 0, 1), 1, "s1_pre_reset");
    reset = 1'b1;
    next();
    reset = 1'b0;
    // C13
    chk_fill(0, "fill_mid_reset");
    search(0, 19'h00100, 1'b0, 10'd8, MISS, 0, "s0_after_reset");
    next();
    // C14
    chk_fill(1, "fill_after_mid_reset");
    next();
    next();
    next();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
